// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared constants and hex-to-segment decode for the seven-segment scanner
package sevseg_pkg;

   // Each digit slot is split into 2**PHASE_W brightness phases
   localparam int PHASE_W = 4;
   localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

   // Active-low segment patterns {a,b,c,d,e,f,g}, MSB = a
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

   // Active-low segment pattern for one hex nibble
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/sevseg_tick_gen.sv
// rtl/sevseg_tick_gen.sv - clock-enable prescaler producing one scan tick every PRESCALE cycles
module sevseg_tick_gen #(
   parameter int PRESCALE = 6250
) (
   input  logic clk,
   input  logic Rst,
   output logic tick_o
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;

   // Terminal count; with PRESCALE=1 the counter stays at 0 and ticks every cycle
   assign tick_o = (pre_cnt_q == CNT_W'(PRESCALE - 1));

   // Next count: wrap to zero on the tick cycle
   always_comb begin
      pre_cnt_d = tick_o ? '0 : pre_cnt_q + CNT_W'(1);
   end

   // Prescale counter register
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) pre_cnt_q <= '0;
      else     pre_cnt_q <= pre_cnt_d;
   end

endmodule

// File: rtl/sevseg_scanner.sv
// rtl/sevseg_scanner.sv - multiplexed seven-segment driver with PWM, snapshot and optional SEVSEG_LZB_EN blanking
module sevseg_scanner
   import sevseg_pkg::*;
#(
   parameter int N_DIGITS       = 8,
   parameter int PRESCALE       = 6250,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  Rst,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic [3:0]            brightness,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            sev_out,
   output logic                  dp_out,
   output logic                  frame_start
);

   localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [DIG_W-1:0]    LAST_DIGIT = DIG_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
   localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);

   logic                  tick;
   logic                  snap_load;

   logic [PHASE_W-1:0]    phase_q, phase_d;
   logic [DIG_W-1:0]      digit_q, digit_d;

   logic [4*N_DIGITS-1:0] snap_data_q, snap_data_d;
   logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [N_DIGITS-1:0]   snap_en_q, snap_en_d;
   logic [3:0]            snap_bright_q, snap_bright_d;

   logic [N_DIGITS-1:0]   an_q, an_d;
   logic [6:0]            sev_q, sev_d;
   logic                  dp_q, dp_d;
   logic                  frame_start_q, frame_start_d;

   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  phase_on;
   logic [N_DIGITS-1:0]   blank;
   logic [N_DIGITS-1:0]   lit;
   logic [6:0]            seg_low;
   logic                  dp_low;

   sevseg_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk    (clk),
      .Rst    (Rst),
      .tick_o (tick)
   );

   // Scan sequencing: phase steps every tick, digit steps when the phase wraps
   always_comb begin
      phase_d   = phase_q;
      digit_d   = digit_q;
      snap_load = 1'b0;
      if (tick) begin
         phase_d = phase_q + PHASE_W'(1);
         if (phase_q == PHASE_MAX) begin
            digit_d   = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
            snap_load = (digit_q == LAST_DIGIT);
         end
      end
   end

   // Frame snapshot: inputs are captured only at the frame boundary so a frame never tears
   always_comb begin
      snap_data_d   = snap_load ? data_in    : snap_data_q;
      snap_dp_d     = snap_load ? dp_in      : snap_dp_q;
      snap_en_d     = snap_load ? digit_en   : snap_en_q;
      snap_bright_d = snap_load ? brightness : snap_bright_q;
      frame_start_d = snap_load;
   end

   // Select the nibble and decimal point of the digit currently being scanned
   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (digit_q == DIG_W'(d)) begin
            cur_nib = snap_data_q[4*d +: 4];
            cur_dp  = snap_dp_q[d];
         end
      end
   end

   // Leading-zero mask: a digit blanks when it and every higher digit are zero; digit 0 always shows
   always_comb begin
      blank = '0;
`ifdef SEVSEG_LZB_EN
      begin : lzb_scan
         logic nz_seen;
         nz_seen = 1'b0;
         for (int d = N_DIGITS - 1; d >= 1; d--) begin
            nz_seen  = nz_seen | (snap_data_q[4*d +: 4] != 4'h0);
            blank[d] = ~nz_seen;
         end
      end
`endif
   end

   // Lit decision and polarity mapping; phase 0 is kept dark to stop ghosting between digits
   always_comb begin
      phase_on = (phase_q != '0) && (phase_q <= snap_bright_q);
      lit      = '0;
      for (int d = 0; d < N_DIGITS; d++) begin
         lit[d] = (digit_q == DIG_W'(d)) && snap_en_q[d] && phase_on && !blank[d];
      end
      seg_low = (|lit) ? hex2seg(cur_nib) : 7'h7F;
      dp_low  = (|lit) ? ~cur_dp : 1'b1;
      an_d    = (AN_ACTIVE_LOW != 0)  ? ~lit    : lit;
      sev_d   = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
      dp_d    = (SEG_ACTIVE_LOW != 0) ? dp_low  : ~dp_low;
   end

   // Scan counters
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         phase_q <= '0;
         digit_q <= '0;
      end else begin
         phase_q <= phase_d;
         digit_q <= digit_d;
      end
   end

   // Snapshot registers; zero after reset so the first frame is dark
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         snap_data_q   <= '0;
         snap_dp_q     <= '0;
         snap_en_q     <= '0;
         snap_bright_q <= '0;
      end else begin
         snap_data_q   <= snap_data_d;
         snap_dp_q     <= snap_dp_d;
         snap_en_q     <= snap_en_d;
         snap_bright_q <= snap_bright_d;
      end
   end

   // Registered display outputs; reset drives them to the inactive level immediately
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         an_q          <= AN_OFF;
         sev_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         frame_start_q <= 1'b0;
      end else begin
         an_q          <= an_d;
         sev_q         <= sev_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign sev_out     = sev_q;
   assign dp_out      = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevseg_scanner.sv
// tb/tb_sevseg_scanner.sv - directed table-driven bench for sevseg_scanner
module tb_sevseg_scanner;

   logic        clk;
   logic        Rst;

   logic [31:0] data;
   logic [7:0]  dp;
   logic [7:0]  en;
   logic [3:0]  bright;
   logic [7:0]  an0;
   logic [6:0]  sev0;
   logic        dpo0;
   logic        fs0;

   logic [3:0]  data1;
   logic [0:0]  dp1;
   logic [0:0]  en1;
   logic [3:0]  bright1;
   logic [0:0]  an1;
   logic [6:0]  sev1;
   logic        dpo1;
   logic        fs1;

   int n_tests;
   int n_fail;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [7:0]  en;
      logic [7:0]  dp;
      logic [3:0]  bright;
      int          t;
      logic [7:0]  an;
      logic [6:0]  sev;
      logic        dpo;
   } vec_t;

   vec_t vecs[$];

   sevseg_scanner #(
      .N_DIGITS (8), .PRESCALE (4), .SEG_ACTIVE_LOW (1), .AN_ACTIVE_LOW (1)
   ) dut (
      .clk (clk), .Rst (Rst), .data_in (data), .dp_in (dp), .digit_en (en),
      .brightness (bright), .an (an0), .sev_out (sev0), .dp_out (dpo0), .frame_start (fs0)
   );

   sevseg_scanner #(
      .N_DIGITS (1), .PRESCALE (1), .SEG_ACTIVE_LOW (1), .AN_ACTIVE_LOW (0)
   ) dut1 (
      .clk (clk), .Rst (Rst), .data_in (data1), .dp_in (dp1), .digit_en (en1),
      .brightness (bright1), .an (an1), .sev_out (sev1), .dp_out (dpo1), .frame_start (fs1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string nm, input logic [31:0] d, input logic [7:0] e,
                               input logic [7:0] p, input logic [3:0] b, input int t,
                               input logic [7:0] a, input logic [6:0] s, input logic o);
      vec_t v;
      v.name = nm; v.data = d; v.en = e; v.dp = p; v.bright = b;
      v.t = t; v.an = a; v.sev = s; v.dpo = o;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Returns on the falling edge of the cycle where frame_start is high (t=0)
   task automatic wait_fs(output int waited);
      waited = -1;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         if (fs0) begin
            waited = i;
            break;
         end
      end
      if (waited < 0) check("frame_start_timeout", 0, 1);
   endtask

   // Reset is already asserted: release and verify the first frame stays dark
   task automatic release_and_check_dark(input string nm);
      int first_fs;
      int lit_cnt;
      first_fs = -1;
      lit_cnt  = 0;
      @(negedge clk);
      Rst = 1'b0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (fs0 && first_fs < 0) first_fs = i;
         if (i < 512 && an0 != 8'hFF) lit_cnt++;
      end
      check({nm, "_first_frame_dark"}, lit_cnt, 0);
      check({nm, "_first_fs_cycle"}, first_fs, 512);
   endtask

   initial begin
      int w;
      int cnt;
      n_tests = 0;
      n_fail  = 0;
      Rst     = 1'b1;
      data    = 32'h76543210;
      dp      = 8'h01;
      en      = 8'hFF;
      bright  = 4'd15;
      data1   = 4'h3;
      dp1     = 1'b1;
      en1     = 1'b1;
      bright1 = 4'd5;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_an", an0, 8'hFF);
      check("rst_sev", sev0, 7'h7F);
      check("rst_dp", dpo0, 1'b1);
      check("rst_fs", fs0, 1'b0);
      check("rst_an_hi", an1, 1'b0);
      release_and_check_dark("por");

      // Frame period with the 8-digit instance
      wait_fs(w);
      wait_fs(w);
      check("frame_period", w, 512);

      // Single-digit, PRESCALE=1, active-high anode instance
      w = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (fs1) begin w = i; break; end
      end
      check("edge_fs_seen", (w > 0), 1);
      w = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (fs1 && w < 0) w = i;
         if (i <= 16) check($sformatf("edge_an_t%0d", i), an1, (i >= 2 && i <= 6) ? 1'b1 : 1'b0);
         if (i == 3) begin
            check("edge_sev", sev1, 7'h06);
            check("edge_dp", dpo1, 1'b0);
         end
         if (i == 10) check("edge_sev_dark", sev1, 7'h7F);
      end
      check("edge_period", w, 16);

      // Table-driven vectors: inputs loaded at the next frame boundary, checked at offset t
      vecs.push_back(mk("scan_t1_dark", 32'h76543210, 8'hFF, 8'h01, 4'd15,   1, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("scan_d0",      32'h76543210, 8'hFF, 8'h01, 4'd15,   5, 8'hFE, 7'h01, 1'b0));
      vecs.push_back(mk("scan_d0_ph15", 32'h76543210, 8'hFF, 8'h01, 4'd15,  64, 8'hFE, 7'h01, 1'b0));
      vecs.push_back(mk("scan_d1_ph0",  32'h76543210, 8'hFF, 8'h01, 4'd15,  65, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("scan_d1",      32'h76543210, 8'hFF, 8'h01, 4'd15,  69, 8'hFD, 7'h4F, 1'b1));
      vecs.push_back(mk("scan_d5",      32'h76543210, 8'hFF, 8'h01, 4'd15, 330, 8'hDF, 7'h24, 1'b1));
      vecs.push_back(mk("scan_d7",      32'h76543210, 8'hFF, 8'h01, 4'd15, 453, 8'h7F, 7'h0F, 1'b1));
      vecs.push_back(mk("br1_on",       32'h76543210, 8'hFF, 8'h01, 4'd1,    8, 8'hFE, 7'h01, 1'b0));
      vecs.push_back(mk("br1_off",      32'h76543210, 8'hFF, 8'h01, 4'd1,    9, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("br0",          32'h76543210, 8'hFF, 8'h01, 4'd0,    5, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("br0_mid",      32'h76543210, 8'hFF, 8'h01, 4'd0,  200, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("en_off_d0",    32'h76543210, 8'hFE, 8'h01, 4'd15,   5, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("en_on_d1",     32'h76543210, 8'hFE, 8'h01, 4'd15,  69, 8'hFD, 7'h4F, 1'b1));
      vecs.push_back(mk("all_f",        32'hFFFFFFFF, 8'hFF, 8'h01, 4'd15,   5, 8'hFE, 7'h38, 1'b0));
      vecs.push_back(mk("lzb_d0",       32'h00000A05, 8'hFF, 8'h00, 4'd15,   5, 8'hFE, 7'h24, 1'b1));
      vecs.push_back(mk("lzb_d1",       32'h00000A05, 8'hFF, 8'h00, 4'd15,  69, 8'hFD, 7'h01, 1'b1));
      vecs.push_back(mk("lzb_d2",       32'h00000A05, 8'hFF, 8'h00, 4'd15, 133, 8'hFB, 7'h08, 1'b1));
      vecs.push_back(mk("zero_d0",      32'h00000000, 8'hFF, 8'h00, 4'd15,   5, 8'hFE, 7'h01, 1'b1));
`ifdef SEVSEG_LZB_EN
      vecs.push_back(mk("lzb_d3",       32'h00000A05, 8'hFF, 8'h00, 4'd15, 197, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("lzb_d7",       32'h00000A05, 8'hFF, 8'h00, 4'd15, 453, 8'hFF, 7'h7F, 1'b1));
      vecs.push_back(mk("zero_d1",      32'h00000000, 8'hFF, 8'h00, 4'd15,  69, 8'hFF, 7'h7F, 1'b1));
`else
      vecs.push_back(mk("lzb_d3",       32'h00000A05, 8'hFF, 8'h00, 4'd15, 197, 8'hF7, 7'h01, 1'b1));
      vecs.push_back(mk("lzb_d7",       32'h00000A05, 8'hFF, 8'h00, 4'd15, 453, 8'h7F, 7'h01, 1'b1));
      vecs.push_back(mk("zero_d1",      32'h00000000, 8'hFF, 8'h00, 4'd15,  69, 8'hFD, 7'h01, 1'b1));
`endif

      foreach (vecs[k]) begin
         data   = vecs[k].data;
         en     = vecs[k].en;
         dp     = vecs[k].dp;
         bright = vecs[k].bright;
         wait_fs(w);
         repeat (vecs[k].t) @(negedge clk);
         check({vecs[k].name, "_an"}, an0, vecs[k].an);
         check({vecs[k].name, "_sev"}, sev0, vecs[k].sev);
         check({vecs[k].name, "_dp"}, dpo0, vecs[k].dpo);
      end

      // Lit cycles per whole frame: 8 digits x 4 clks per phase x brightness
      data = 32'h76543210; en = 8'hFF; dp = 8'h01;
      for (int b = 0; b < 2; b++) begin
         bright = (b == 0) ? 4'd1 : 4'd15;
         wait_fs(w);
         cnt = 0;
         for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            if (an0 != 8'hFF) cnt++;
         end
         check((b == 0) ? "lit_cycles_br1" : "lit_cycles_br15", cnt, (b == 0) ? 32 : 480);
      end

      // Mid-frame input change must not tear the displayed frame
      bright = 4'd15;
      wait_fs(w);
      wait_fs(w);
      repeat (100) @(negedge clk);
      data = 32'hFFFFFFFF;
      repeat (33) @(negedge clk);
      check("snap_hold_an", an0, 8'hFB);
      check("snap_hold_sev", sev0, 7'h12);
      wait_fs(w);
      check("snap_fs_cycle_sev", sev0, 7'h0F);
      check("snap_fs_cycle_an", an0, 8'h7F);
      repeat (5) @(negedge clk);
      check("snap_new_sev", sev0, 7'h38);

      // Asynchronous reset in the middle of a lit slot
      data = 32'h76543210;
      wait_fs(w);
      wait_fs(w);
      repeat (5) @(negedge clk);
      check("pre_midrst_an", an0, 8'hFE);
      Rst = 1'b1;
      #1;
      check("midrst_an", an0, 8'hFF);
      check("midrst_sev", sev0, 7'h7F);
      check("midrst_dp", dpo0, 1'b1);
      check("midrst_fs", fs0, 1'b0);
      release_and_check_dark("midrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
